// File: rtl/ahb_bridge_pkg.sv
// rtl/ahb_bridge_pkg.sv - shared HTRANS codes, arbiter FSM states and clog2 helper
package ahb_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_e;

    // Ceiling log2, minimum result 1 so index buses are never zero-width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational round-robin picker: (req, rr_ptr) -> one-hot winner + valid
// Ports:
//   req     in  N      request vector
//   rr_ptr  in  IDX_W  index of the last winner; search starts at rr_ptr+1 with wrap
//   grant   out N      one-hot winner (all zero when valid=0)
//   valid   out 1      at least one request present
module ahb_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        // Offset N wraps back to rr_ptr itself, so a lone requester re-wins.
        for (int off = 1; off <= N; off++) begin
            idx = IDX_W'((int'(rr_ptr) + off) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB arbiter with lock and burst protection
// Optional feature macro: ARB_TIMEOUT_EN (forced handover after MAX_HOLD unchanged-grant updates).
// Ports:
//   Hclk      in   1        bus clock
//   Hreset    in   1        synchronous active-high reset
//   Hbusreq   in   N        per-master bus request
//   Hlock     in   N        per-master locked-transfer request
//   Htrans    in   2        HTRANS of current address-phase owner
//   Hready    in   1        qualifies every state update
//   Hgrant    out  N        registered one-hot grant
//   Hmaster   out  clog2(N) registered address-phase owner index
//   Hmastlock out  1        registered locked-sequence flag
module ahb_bus_arbiter
    import ahb_bridge_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input  logic                          Hclk,
    input  logic                          Hreset,
    input  logic [NUM_MASTERS-1:0]        Hbusreq,
    input  logic [NUM_MASTERS-1:0]        Hlock,
    input  logic [1:0]                    Htrans,
    input  logic                          Hready,
    output logic [NUM_MASTERS-1:0]        Hgrant,
    output logic [clog2(NUM_MASTERS)-1:0] Hmaster,
    output logic                          Hmastlock
);

    localparam int IDX_W = clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || DEFAULT_MASTER < 0 ||
        DEFAULT_MASTER >= NUM_MASTERS || MAX_HOLD < 2) begin : g_bad_params
        $error("ahb_bus_arbiter: illegal parameter combination");
    end

    function automatic logic [IDX_W-1:0] oh2idx(input logic [NUM_MASTERS-1:0] oh);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) r = r | IDX_W'(i);
        end
        return r;
    endfunction

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       master_q, master_d;
    logic                   mastlock_q, mastlock_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    arb_state_e             state_q, state_d;

    logic [NUM_MASTERS-1:0] pick;
    logic                   pick_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic                   burst, owner_req, owner_lock, timeout_pending, hold;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(MAX_HOLD) + 1;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    ahb_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (Hbusreq),
        .rr_ptr (rr_ptr_q),
        .grant  (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        grant_idx       = oh2idx(grant_q);
        burst           = (Htrans == HTRANS_SEQ) || (Htrans == HTRANS_BUSY);
        owner_req       = Hbusreq[grant_idx];
        owner_lock      = Hlock[grant_idx];
        timeout_pending = 1'b0;
`ifdef ARB_TIMEOUT_EN
        // Waive bus-hold only when someone else is waiting and no lock is active.
        timeout_pending = (hold_cnt_q >= CNT_W'(MAX_HOLD - 1)) &&
                          (|(Hbusreq & ~grant_q)) && (state_q != ST_LOCK);
`endif
        hold = burst || (owner_req && owner_lock) || (owner_req && !timeout_pending);

        grant_d  = hold ? grant_q : (pick_valid ? pick : DEFAULT_GRANT);
        // Parking on the default master is not a win; rr_ptr keeps the last real winner.
        rr_ptr_d = (!hold && pick_valid) ? oh2idx(pick) : rr_ptr_q;
        master_d   = grant_idx;
        mastlock_d = owner_lock;

`ifdef ARB_TIMEOUT_EN
        if (grant_d != grant_q) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q < CNT_W'(MAX_HOLD - 1)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
`endif

        state_d = state_q;
        case (state_q)
            ST_PARK: if (|(grant_d & Hbusreq)) state_d = ST_OWN;
            ST_OWN: begin
                if (owner_req && owner_lock) state_d = ST_LOCK;
                else if (!(|Hbusreq))        state_d = ST_PARK;
            end
            ST_LOCK: begin
                if ((!owner_lock || !owner_req) && !burst)
                    state_d = (|Hbusreq) ? ST_OWN : ST_PARK;
            end
            default: state_d = ST_PARK;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            grant_q    <= DEFAULT_GRANT;
            master_q   <= IDX_W'(DEFAULT_MASTER);
            mastlock_q <= 1'b0;
            rr_ptr_q   <= '0;
            state_q    <= ST_PARK;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else if (Hready) begin
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= state_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign Hgrant    = grant_q;
    assign Hmaster   = master_q;
    assign Hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - directed self-checking bench for ahb_bus_arbiter
module tb_ahb_bus_arbiter;

    logic       clk;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int n_cmp;
    int n_err;

    ahb_bus_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0),
        .MAX_HOLD       (16)
    ) dut (
        .Hclk      (clk),
        .Hreset    (hreset),
        .Hbusreq   (hbusreq),
        .Hlock     (hlock),
        .Htrans    (htrans),
        .Hready    (hready),
        .Hgrant    (hgrant),
        .Hmaster   (hmaster),
        .Hmastlock (hmastlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] m,
                           input logic l);
        chk({tag, ".grant"}, {4'b0, hgrant}, {4'b0, g});
        chk({tag, ".master"}, {6'b0, hmaster}, {6'b0, m});
        chk({tag, ".mastlock"}, {7'b0, hmastlock}, {7'b0, l});
    endtask

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    initial begin
        logic [3:0] exp_g;
        n_cmp   = 0;
        n_err   = 0;
        hreset  = 1'b1;
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        htrans  = T_IDLE;
        hready  = 1'b1;
        tick();
        tick();
        hreset = 1'b0;

        // 1: reset state, parked on M0 for 10 cycles
        chk_all("reset", 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("park.grant", {4'b0, hgrant}, 8'h01);
        end
        chk("park.master", {6'b0, hmaster}, 8'h00);

        // 2: M1 then M2; Hmaster trails by one update
        hbusreq = 4'b0110;
        tick();
        chk_all("rr1", 4'b0010, 2'd0, 1'b0);
        htrans = T_NSEQ;
        tick();
        chk_all("rr1_hold", 4'b0010, 2'd1, 1'b0);
        hbusreq = 4'b0100;
        htrans  = T_IDLE;
        tick();
        chk_all("rr2", 4'b0100, 2'd1, 1'b0);
        tick();
        chk_all("rr2_own", 4'b0100, 2'd2, 1'b0);

        // 3: M1 burst; M3 waits until burst ends
        hbusreq = 4'b0010;
        tick();
        chk("to_m1.grant", {4'b0, hgrant}, 8'h02);
        tick();
        chk("to_m1.master", {6'b0, hmaster}, 8'h01);
        hbusreq = 4'b1010;
        htrans  = T_NSEQ;
        tick();
        chk("burst_b1", {4'b0, hgrant}, 8'h02);
        hbusreq = 4'b1000;
        htrans  = T_SEQ;
        for (int b = 2; b <= 4; b++) begin
            tick();
            chk("burst_seq", {4'b0, hgrant}, 8'h02);
        end
        htrans = T_IDLE;
        tick();
        chk_all("burst_end", 4'b1000, 2'd1, 1'b0);
        tick();
        chk_all("m3_own", 4'b1000, 2'd3, 1'b0);

        // 4: M2 locked sequence held 20 cycles against competing requests
        hbusreq = 4'b0100;
        hlock   = 4'b0100;
        tick();
        chk_all("lock_grant", 4'b0100, 2'd3, 1'b0);
        tick();
        chk_all("lock_on", 4'b0100, 2'd2, 1'b1);
        hbusreq = 4'b1111;
        htrans  = T_NSEQ;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("lock_hold.grant", {4'b0, hgrant}, 8'h04);
            chk("lock_hold.mlock", {7'b0, hmastlock}, 8'h01);
        end
        hlock   = 4'b0000;
        hbusreq = 4'b1011;
        htrans  = T_IDLE;
        tick();
        chk_all("lock_release", 4'b1000, 2'd2, 1'b0);

        // 5: Hready low freezes a pending handover
        hbusreq = 4'b0011;
        hready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("frozen", 4'b1000, 2'd2, 1'b0);
        end
        hready = 1'b1;
        tick();
        chk_all("thaw", 4'b0001, 2'd3, 1'b0);

        // 6: two persistent unlocked requesters
        htrans = T_NSEQ;
        for (int i = 1; i <= 40; i++) begin
            tick();
`ifdef ARB_TIMEOUT_EN
            exp_g = (((i / 16) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
            exp_g = 4'b0001;
`endif
            chk("timeout.grant", {4'b0, hgrant}, {4'b0, exp_g});
        end

        // reset mid-ownership returns to park immediately
        hbusreq = 4'b0010;
        htrans  = T_IDLE;
        tick();
        chk("pre_reset.grant", {4'b0, hgrant}, 8'h02);
        hreset = 1'b1;
        tick();
        chk_all("mid_reset", 4'b0001, 2'd0, 1'b0);
        hreset  = 1'b0;
        hbusreq = 4'b0000;
        tick();
        chk_all("post_reset", 4'b0001, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
